reaction_ctrl: RTL
==================

# reaction_ctrl

Sequencing controller for the reaction-timer datapath. It waits for a start press, inserts a pseudo-random delay, lights the GO indicator, measures press latency in millisecond ticks, and presents a 24-bit score with a one-cycle commit strobe. The high-score register samples that strobe. A score of 0 always means "no valid result", so a foul never reaches the high-score logic.

## Interface
Parameters:
- `CNT_W`, 24, width of the score and reaction counter.
- `TICK_DIV`, 50000, clock cycles per timing tick (1 ms at 50 MHz).
- `MIN_WAIT`, 1000, minimum random delay in ticks.
- `WAIT_BITS`, 11, number of LFSR bits added to `MIN_WAIT`.
- `LFSR_SEED`, 16'hACE1, reset value of the 16-bit LFSR; must be nonzero.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn`, in, 1: debounced, synchronous level, active-high.
- `led_go`, out, 1: GO indicator.
- `score`, out, CNT_W: last result; 0 means no valid result.
- `score_valid`, out, 1: one-cycle commit strobe for the high-score register.
- `foul`, out, 1: last round was pressed early.
- `busy`, out, 1: high in WAIT and GO.

## Operation
- Press detection: `press = btn & ~btn_q`, where `btn_q` is `btn` registered. `btn_q` resets to 0. A button held through reset is therefore seen as a press on the first sampled cycle.
- LFSR:
  - 16-bit Fibonacci, taps 16/14/13/11, shifts every clock.
  - Delay is `MIN_WAIT + lfsr[WAIT_BITS-1:0]`, latched when WAIT is entered.
- Tick prescaler:
  - Counts 0..`TICK_DIV`-1 and pulses `tick` on the terminal count.
  - Cleared on entry to WAIT and on entry to GO, so the first tick comes exactly `TICK_DIV` cycles after entry.
- States and transitions:
  - IDLE: all indicators low. On press, go to WAIT.
  - WAIT: `busy`=1. The delay counter decrements on each tick.
    - Press before expiry: go to FOUL.
    - Tick while the counter is 1: go to GO and clear the reaction counter.
  - GO: `led_go`=1, `busy`=1. The reaction counter increments on each tick and saturates at 2^CNT_W-1. On press, go to DONE.
  - DONE: `score` is loaded with the counter, forced to 1 if the counter is 0. `score_valid` pulses in the entry cycle. Press goes to WAIT (new round).
  - FOUL: `foul`=1 and `score` is cleared to 0, with no `score_valid` pulse. Press goes to IDLE.
- `foul` clears on the next exit from FOUL. `score` holds until it is next loaded or cleared.
- Simultaneous events:
  - Press and tick in the same cycle: the press wins.
  - In WAIT, a press on the expiry tick gives FOUL.
  - In GO, the coincident tick is not counted.
- Saturation: GO never times out. At the maximum count, `score` becomes 0xFFFFFF on press.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `led_go` 0, `score` 0, `score_valid` 0, `foul` 0, `busy` 0, LFSR `LFSR_SEED`, prescaler 0.
- A press sampled at edge n changes state at edge n; new outputs are visible after edge n.
- The `score_valid` high cycle coincides with the first cycle `score` shows the new value.
- WAIT-to-GO latency is exactly `delay*TICK_DIV` cycles.
- Reset asserted mid-round returns to IDLE immediately. No strobe is issued, and `score` is cleared.

## Structure
- Package `reaction_pkg` holds:
  - the state enum (IDLE, WAIT, GO, DONE, FOUL);
  - the LFSR tap mask and default seed;
  - the default `CNT_W`.
- Sub-module `tick_prescaler`, with parameter `TICK_DIV` and ports `clk`, `rst_n`, `clr`, `tick`.
- The FSM, LFSR and counters live in `reaction_ctrl`.

## Test plan
All scenarios use `TICK_DIV`=4, `MIN_WAIT`=2, `WAIT_BITS`=2.
- Normal round: press, then press 10 ticks after `led_go` rises.
  - Expect `score`=10, one `score_valid` pulse, `foul`=0, and `led_go` low after the press.
- Early press: press, then press again 1 tick later.
  - Expect FOUL, `foul`=1, `score`=0, no `score_valid`, and a return to IDLE on the next press.
- Instant press: press in the first cycle of GO.
  - Expect `score`=1 with a `score_valid` pulse.
- Boundary collisions:
  - Press on the expiry tick in WAIT: expect FOUL.
  - Press on a tick edge in GO: expect the count to exclude that tick.
- Saturation: with `CNT_W`=4, wait 20 ticks in GO, then press.
  - Expect `score`=15.
- Reset and seed:
  - Assert `rst_n`=0 mid-GO: expect all outputs at reset values in the same cycle and the state at IDLE.
  - Check that the WAIT length matches the LFSR value derived from the seed (2..5 ticks).

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_GO   = 3'd2,
    ST_DONE = 3'd3,
    ST_FOUL = 3'd4
  } state_e;

  // Fibonacci taps 16/14/13/11 expressed as bit positions 15/13/12/10.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam int          CNT_W_DEF     = 24;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0]  TERM = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: a clear restarts the period so the first tick lands TICK_DIV cycles later.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: random delay, GO indicator, latency measurement
// and a registered score with a one-cycle commit strobe.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int          CNT_W     = CNT_W_DEF,
  parameter int          TICK_DIV  = 50000,
  parameter int          MIN_WAIT  = 1000,
  parameter int          WAIT_BITS = 11,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  output logic             led_go,
  output logic [CNT_W-1:0] score,
  output logic             score_valid,
  output logic             foul,
  output logic             busy
);

  localparam int               DLY_W   = $clog2(MIN_WAIT + (2 ** WAIT_BITS)) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic               btn_q;
  logic [15:0]        lfsr_q;
  logic [DLY_W-1:0]   dly_q, dly_d, dly_load_s;
  logic [CNT_W-1:0]   rcnt_q, rcnt_d, score_q, score_d;
  logic               valid_q, valid_d, foul_q, foul_d;
  logic               led_q, led_d, busy_q, busy_d;
  logic               press_s, tick_s, clr_s;

  assign press_s    = btn & ~btn_q;
  assign dly_load_s = DLY_W'(MIN_WAIT) + DLY_W'(lfsr_q[WAIT_BITS-1:0]);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Next state, counters and output values; a press always takes priority over a tick.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    rcnt_d  = rcnt_q;
    score_d = score_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (press_s) begin
          state_d = ST_WAIT;
          dly_d   = dly_load_s;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT: begin
        if (press_s) begin
          state_d = ST_FOUL;
          score_d = '0;
        end else if (tick_s) begin
          if (dly_q == DLY_W'(1)) begin
            state_d = ST_GO;
            rcnt_d  = '0;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end else begin
          dly_d = dly_q;
        end
      end
      ST_GO: begin
        if (press_s) begin
          state_d = ST_DONE;
          score_d = (rcnt_q == '0) ? CNT_ONE : rcnt_q;
          valid_d = 1'b1;
        end else if (tick_s && (rcnt_q != CNT_MAX)) begin
          rcnt_d = rcnt_q + CNT_ONE;
        end else begin
          rcnt_d = rcnt_q;
        end
      end
      ST_FOUL: begin
        if (press_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FOUL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    clr_s  = (state_d != state_q) && ((state_d == ST_WAIT) || (state_d == ST_GO));
    led_d  = (state_d == ST_GO);
    busy_d = (state_d == ST_WAIT) || (state_d == ST_GO);
    foul_d = (state_d == ST_FOUL);
  end

  // State, LFSR, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      btn_q   <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      dly_q   <= '0;
      rcnt_q  <= '0;
      score_q <= '0;
      valid_q <= 1'b0;
      foul_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn;
      lfsr_q  <= lfsr_step(lfsr_q);
      dly_q   <= dly_d;
      rcnt_q  <= rcnt_d;
      score_q <= score_d;
      valid_q <= valid_d;
      foul_q  <= foul_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led_go      = led_q;
  assign score       = score_q;
  assign score_valid = valid_q;
  assign foul        = foul_q;
  assign busy        = busy_q;

endmodule
